riscv_memresp: RTL and testbench

Response-side companion to the memory access buffer. It tracks requests issued to the memory system, captures each in-order response (ack_i/err_i/q_i) and returns it to the CPU pipeline through a valid/ready handshake. It buffers responses the pipeline cannot yet accept, throttles new issues through stall_o, and silently discards responses that belong to requests flushed by clr_i.

---
 rtl/riscv_memresp.sv | 178 +++++++++++++++++
 tb/tb_riscv_memresp.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/riscv_memresp.sv
// riscv_memresp: response side of the memory access buffer.
//   Tracks the requests issued to memory, captures each in-order response
//   (ack_i/err_i/q_i) and hands it to the CPU over valid_o/ready_i. Responses
//   the CPU cannot take yet are buffered. Issue is throttled with stall_o so
//   that every outstanding response is guaranteed a buffer slot. Responses
//   belonging to requests flushed by clr_i are silently dropped.
// Ports:
//   clk_i, rst_ni               clock, async active-low reset
//   clr_i                       flush buffered and in-flight responses
//   req_i, we_i                 request issued to memory, write flag
//   ack_i, err_i, q_i           memory response (ok / error, read data)
//   valid_o, ready_i            response handshake towards the CPU
//   err_o, we_o, q_o            presented response contents
//   stall_o                     no new request may be issued
//   pending_o                   outstanding request count
//   empty_o                     response FIFO empty
//   overflow_o                  sticky protocol-violation flag
module riscv_memresp #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter int MAX_PENDING = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           req_i,
    input  logic                           we_i,
    input  logic                           ack_i,
    input  logic                           err_i,
    input  logic [XLEN-1:0]                q_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           err_o,
    output logic                           we_o,
    output logic [XLEN-1:0]                q_o,
    output logic                           stall_o,
    output logic [$clog2(MAX_PENDING):0]   pending_o,
    output logic                           empty_o,
    output logic                           overflow_o
);
    localparam int PW = $clog2(MAX_PENDING) + 1;
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam int SW = ((PW > CW) ? PW : CW) + 1;
    localparam int QA = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int TA = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

    typedef struct packed {
        logic            err;
        logic            we;
        logic [XLEN-1:0] q;
    } resp_t;

    function automatic logic [QA-1:0] qinc(input logic [QA-1:0] p);
        return (p == QA'(QUEUE_DEPTH - 1)) ? '0 : p + QA'(1);
    endfunction

    function automatic logic [TA-1:0] tinc(input logic [TA-1:0] p);
        return (p == TA'(MAX_PENDING - 1)) ? '0 : p + TA'(1);
    endfunction

    logic [PW-1:0] pend_q, pend_d, drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QA-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [TA-1:0] trd_q, trd_d, twr_q, twr_d;
    logic          ovf_q, ovf_d;
    resp_t         rmem_q [QUEUE_DEPTH];
    resp_t         rmem_d [QUEUE_DEPTH];
    logic          tmem_q [MAX_PENDING];
    logic          tmem_d [MAX_PENDING];

    logic  resp, resp_ok, live, issue, stall;
    logic  fifo_empty, fifo_full, bypass, push, pop;
    resp_t nresp, head;

    always_comb begin
        resp    = ack_i | err_i;
        // Credit check: pending responses plus buffered ones must fit the FIFO.
        stall   = (pend_q == PW'(MAX_PENDING)) |
                  ((SW'(pend_q) + SW'(cnt_q)) >= SW'(QUEUE_DEPTH));
        issue   = req_i & ~stall;
        resp_ok = resp & (pend_q != '0);
        // A response is live only if it belongs to a request not flushed.
        live    = resp_ok & (drop_q == '0) & ~clr_i;

        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CW'(QUEUE_DEPTH));
        pop        = ready_i & ~fifo_empty;
        bypass     = live & fifo_empty & ready_i;
        push       = live & ~bypass & (~fifo_full | pop);

        nresp.err = err_i;
        nresp.we  = tmem_q[trd_q];
        nresp.q   = (err_i | tmem_q[trd_q]) ? '0 : q_i;

        if (!fifo_empty) head = rmem_q[rd_q];
        else if (live)   head = nresp;
        else             head = '0;

        pend_d = pend_q + PW'(issue) - PW'(resp_ok);
        ovf_d  = ovf_q | (req_i & stall) | (resp & (pend_q == '0)) |
                 (live & ~bypass & fifo_full & ~pop);

        // On a flush everything still owed (minus a response arriving now)
        // becomes a response to be dropped.
        if (clr_i)                          drop_d = pend_q - PW'(resp_ok);
        else if (resp_ok && drop_q != '0)   drop_d = drop_q - PW'(1);
        else                                drop_d = drop_q;

        rmem_d = rmem_q;
        tmem_d = tmem_q;
        cnt_d  = cnt_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        trd_d  = trd_q;
        twr_d  = twr_q;

        if (clr_i) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
            trd_d = '0;
            twr_d = '0;
            // A request in the flush cycle survives as the first new tag.
            if (issue) begin
                tmem_d[0] = we_i;
                twr_d     = tinc('0);
            end
        end else begin
            if (push) begin
                rmem_d[wr_q] = nresp;
                wr_d         = qinc(wr_q);
            end
            if (pop) rd_d = qinc(rd_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (issue) begin
                tmem_d[twr_q] = we_i;
                twr_d         = tinc(twr_q);
            end
            if (live) trd_d = tinc(trd_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            trd_q  <= '0;
            twr_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) rmem_q[i] <= '0;
            for (int i = 0; i < MAX_PENDING; i++) tmem_q[i] <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            trd_q  <= trd_d;
            twr_q  <= twr_d;
            ovf_q  <= ovf_d;
            rmem_q <= rmem_d;
            tmem_q <= tmem_d;
        end
    end

    assign valid_o    = ~fifo_empty | live;
    assign err_o      = head.err;
    assign we_o       = head.we;
    assign q_o        = head.q;
    assign stall_o    = stall;
    assign pending_o  = pend_q;
    assign empty_o    = fifo_empty;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_riscv_memresp.sv
// Directed bench for riscv_memresp. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_riscv_memresp;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        clr_i, req_i, we_i, ack_i, err_i, ready_i;
    logic [31:0] q_i;
    logic        valid_o, err_o, we_o, stall_o, empty_o, overflow_o;
    logic [31:0] q_o;
    logic [1:0]  pending_o;
    int n_checks = 0, n_err = 0;

    riscv_memresp #(.XLEN(32), .QUEUE_DEPTH(2), .MAX_PENDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .req_i(req_i), .we_i(we_i),
        .ack_i(ack_i), .err_i(err_i), .q_i(q_i), .valid_o(valid_o), .ready_i(ready_i),
        .err_o(err_o), .we_o(we_o), .q_o(q_o), .stall_o(stall_o), .pending_o(pending_o),
        .empty_o(empty_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to the next falling edge and drive a fresh input vector.
    task automatic cyc(input logic clr, input logic req, input logic we, input logic ack,
                       input logic err, input logic [31:0] q, input logic rdy);
        @(negedge clk_i);
        clr_i = clr; req_i = req; we_i = we; ack_i = ack; err_i = err; q_i = q; ready_i = rdy;
        #1;
    endtask

    task automatic test_reset;
        clr_i = 0; req_i = 0; we_i = 0; ack_i = 0; err_i = 0; q_i = '0; ready_i = 0;
        #1;
        n_checks++; if (valid_o !== 1'b0)    begin n_err++; $display("FAIL reset_valid got %0h exp 0", valid_o); end
        n_checks++; if (q_o !== 32'h0)       begin n_err++; $display("FAIL reset_q got %0h exp 0", q_o); end
        n_checks++; if (stall_o !== 1'b0)    begin n_err++; $display("FAIL reset_stall got %0h exp 0", stall_o); end
        n_checks++; if (pending_o !== 2'd0)  begin n_err++; $display("FAIL reset_pending got %0d exp 0", pending_o); end
        n_checks++; if (empty_o !== 1'b1)    begin n_err++; $display("FAIL reset_empty got %0h exp 1", empty_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0h exp 0", overflow_o); end
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic test_bypass;
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 1, 0, 32'hDEADBEEF, 1);
        n_checks++; if (pending_o !== 2'd1) begin n_err++; $display("FAIL byp_pend1 got %0d exp 1", pending_o); end
        n_checks++; if (valid_o !== 1'b1)   begin n_err++; $display("FAIL byp_valid got %0h exp 1", valid_o); end
        n_checks++; if (q_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL byp_q got %0h exp deadbeef", q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (pending_o !== 2'd0) begin n_err++; $display("FAIL byp_pend0 got %0d exp 0", pending_o); end
        n_checks++; if (valid_o !== 1'b0 || empty_o !== 1'b1) begin n_err++; $display("FAIL byp_idle got v=%0h e=%0h exp v=0 e=1", valid_o, empty_o); end
    endtask

    task automatic test_buffer;
        cyc(0, 1, 0, 0, 0, 32'h0, 0);
        n_checks++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL buf_stall_a got %0h exp 0", stall_o); end
        cyc(0, 1, 0, 0, 0, 32'h0, 0);
        n_checks++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL buf_stall_b got %0h exp 0", stall_o); end
        cyc(0, 0, 0, 1, 0, 32'h11, 0);
        n_checks++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL buf_stall_c got %0h exp 1", stall_o); end
        cyc(0, 0, 0, 1, 0, 32'h22, 0);
        n_checks++; if (empty_o !== 1'b0) begin n_err++; $display("FAIL buf_empty got %0h exp 0", empty_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        n_checks++; if (stall_o !== 1'b1 || pending_o !== 2'd0) begin n_err++; $display("FAIL buf_full got s=%0h p=%0d exp s=1 p=0", stall_o, pending_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (valid_o !== 1'b1 || q_o !== 32'h11) begin n_err++; $display("FAIL buf_first got v=%0h q=%0h exp v=1 q=11", valid_o, q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (valid_o !== 1'b1 || q_o !== 32'h22) begin n_err++; $display("FAIL buf_second got v=%0h q=%0h exp v=1 q=22", valid_o, q_o); end
        n_checks++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL buf_unstall got %0h exp 0", stall_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (empty_o !== 1'b1 || valid_o !== 1'b0) begin n_err++; $display("FAIL buf_drained got e=%0h v=%0h exp e=1 v=0", empty_o, valid_o); end
    endtask

    task automatic test_write_err;
        cyc(0, 1, 1, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 1, 0, 32'h1234, 1);
        n_checks++; if (valid_o !== 1'b1 || we_o !== 1'b1 || q_o !== 32'h0 || err_o !== 1'b0)
            begin n_err++; $display("FAIL wr_resp got v=%0h we=%0h err=%0h q=%0h exp v=1 we=1 err=0 q=0", valid_o, we_o, err_o, q_o); end
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 1, 32'hFFFF, 1);
        n_checks++; if (valid_o !== 1'b1 || err_o !== 1'b1 || q_o !== 32'h0 || we_o !== 1'b0)
            begin n_err++; $display("FAIL err_resp got v=%0h err=%0h we=%0h q=%0h exp v=1 err=1 we=0 q=0", valid_o, err_o, we_o, q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
    endtask

    task automatic test_clear;
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (pending_o !== 2'd2) begin n_err++; $display("FAIL clr_pend2 got %0d exp 2", pending_o); end
        cyc(0, 0, 0, 1, 0, 32'hAA, 1);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL clr_drop1 got %0h exp 0", valid_o); end
        cyc(0, 0, 0, 1, 0, 32'hBB, 1);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL clr_drop2 got %0h exp 0", valid_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (pending_o !== 2'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL clr_idle got p=%0d e=%0h exp p=0 e=1", pending_o, empty_o); end
        // Request issued together with the flush must survive it.
        cyc(0, 1, 0, 0, 0, 32'h0, 1);
        cyc(1, 1, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (pending_o !== 2'd2) begin n_err++; $display("FAIL clrreq_pend got %0d exp 2", pending_o); end
        cyc(0, 0, 0, 1, 0, 32'h99, 1);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL clrreq_drop got %0h exp 0", valid_o); end
        cyc(0, 0, 0, 1, 0, 32'h55, 1);
        n_checks++; if (valid_o !== 1'b1 || q_o !== 32'h55) begin n_err++; $display("FAIL clrreq_keep got v=%0h q=%0h exp v=1 q=55", valid_o, q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (pending_o !== 2'd0) begin n_err++; $display("FAIL clrreq_pend0 got %0d exp 0", pending_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL clr_noovf got %0h exp 0", overflow_o); end
    endtask

    task automatic test_back_to_back;
        cyc(0, 1, 0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 0, 32'h31, 0);
        cyc(0, 0, 0, 1, 0, 32'h32, 1);
        n_checks++; if (valid_o !== 1'b1 || q_o !== 32'h31) begin n_err++; $display("FAIL b2b_head got v=%0h q=%0h exp v=1 q=31", valid_o, q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        n_checks++; if (empty_o !== 1'b0 || q_o !== 32'h32 || stall_o !== 1'b0)
            begin n_err++; $display("FAIL b2b_one got e=%0h q=%0h s=%0h exp e=0 q=32 s=0", empty_o, q_o, stall_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (valid_o !== 1'b1 || q_o !== 32'h32) begin n_err++; $display("FAIL b2b_tail got v=%0h q=%0h exp v=1 q=32", valid_o, q_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %0h exp 1", empty_o); end
    endtask

    task automatic test_overflow;
        cyc(0, 0, 0, 1, 0, 32'h77, 1);
        n_checks++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ovf_valid got %0h exp 0", valid_o); end
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (overflow_o !== 1'b1 || pending_o !== 2'd0) begin n_err++; $display("FAIL ovf_set got o=%0h p=%0d exp o=1 p=0", overflow_o, pending_o); end
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        n_checks++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0h exp 1", overflow_o); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_buffer();
        test_write_err();
        test_clear();
        test_back_to_back();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
